// File: rtl/rv32_pkg.sv
// rv32 shared types and constants.
// Fetch-to-decode bundle and PC source select.
package rv32;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    NEXT = 2'd0,
    ADDR = 2'd1,
    TRAP = 2'd2
  } pc_t;

  typedef struct packed {
    word_t pc;
    word_t ir;
  } id_t;

  localparam word_t NOP        = 32'h0000_0013;
  localparam word_t RESET_ADDR = 32'h0000_0000;
  localparam word_t TRAP_ADDR  = 32'h0000_0004;

endpackage

// File: rtl/rv32_fifo.sv
// Two-entry synchronous FIFO with clear.
// Push into a full FIFO is accepted only alongside a pop.
module rv32_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv32_fetch.sv
// rv32 instruction fetch stage.
// PC, imem request channel, tag/output FIFOs, redirect kill.
module rv32_fetch
  import rv32::*;
#(
  parameter word_t RESET_PC = RESET_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output id_t         id,
  output logic        id_valid,
  input  logic        id_ready,
  input  pc_t         pc_sel,
  input  logic [31:0] pc_target
);

  word_t      pc;
  word_t      redirect_pc;
  word_t      tag_head;
  id_t        out_head;
  id_t        out_wdata;
  logic [1:0] outstanding;
  logic [1:0] out_next;
  logic [1:0] out_count;
  logic [1:0] kill;
  logic [2:0] credit;
  logic       req;
  logic       resp;
  logic       id_fire;
  logic       redirect;
  logic       drop;

  assign id_valid = out_count != 2'd0;
  assign id_fire  = id_valid && id_ready;
  assign id       = id_valid ? out_head : '{pc: 32'h0, ir: NOP};

  // Credit covers both in-flight and buffered slots.
  assign credit = {1'b0, outstanding} + {1'b0, out_count}
                - {2'b00, id_fire};

  assign imem_valid = !reset && (credit < 3'd2);
  assign imem_addr  = pc;
  assign req        = imem_valid && imem_ready;
  assign resp       = imem_rvalid;

  assign redirect    = pc_sel != NEXT;
  assign redirect_pc = (pc_sel == TRAP) ? TRAP_ADDR
                     : (pc_target & 32'hFFFF_FFFC);
  assign drop        = redirect || (kill != 2'd0);
  assign out_next    = outstanding + {1'b0, req} - {1'b0, resp};

  assign out_wdata = '{pc: tag_head, ir: imem_rdata};

  rv32_fifo #(.W(32)) u_tag (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .push  (req),
    .wdata (pc),
    .pop   (resp),
    .rdata (tag_head),
    .count (outstanding)
  );

  rv32_fifo #(.W($bits(id_t))) u_out (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (resp && !drop),
    .wdata (out_wdata),
    .pop   (id_fire),
    .rdata (out_head),
    .count (out_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_PC;
      kill <= 2'd0;
    end else begin
      if (redirect)  pc <= redirect_pc;
      else if (req)  pc <= pc + 32'd4;
      if (redirect)
        kill <= out_next;
      else if (resp && (kill != 2'd0))
        kill <= kill - 2'd1;
    end
  end

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed and randomised-memory bench for rv32_fetch.
// In-order memory model with configurable response latency.
module tb_rv32_fetch;
  import rv32::*;

  logic  clk;
  logic  reset;
  logic  imem_valid;
  logic  imem_ready;
  word_t imem_addr;
  logic  imem_rvalid;
  word_t imem_rdata;
  id_t   id;
  logic  id_valid;
  logic  id_ready;
  pc_t   pc_sel;
  word_t pc_target;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int req_cnt  = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  typedef struct {
    word_t a;
    int    due;
  } mreq_t;

  mreq_t mq[$];

  rv32_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_valid  (imem_valid),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id          (id),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .pc_sel      (pc_sel),
    .pc_target   (pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the address as the instruction word.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'hDEAD_BEEF;
    end else begin
      if (imem_valid && imem_ready) begin
        mq.push_back('{imem_addr,
          cyc + int'($urandom_range(lat_max, lat_min))});
        req_cnt++;
      end
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mq[0].a;
        void'(mq.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'hDEAD_BEEF;
      end
    end
    cyc++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_id(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id_valid && id_ready) && n < 20);
    check({tag, "_seen"}, {31'b0, id_valid}, 32'd1);
    check({tag, "_pc"}, id.pc, exp);
    check({tag, "_ir"}, id.ir, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    pc_sel = NEXT;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int got_n;
    word_t exp_pc;

    reset      = 1'b1;
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    pc_sel     = NEXT;
    pc_target  = 32'h0;

    // Reset state and ideal streaming
    repeat (3) @(negedge clk);
    check("rst_imem_valid", {31'b0, imem_valid}, 32'd0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_pc", id.pc, 32'h0);
    check("rst_id_ir", id.ir, NOP);
    reset = 1'b0;
    #1;
    check("c0_imem_valid", {31'b0, imem_valid}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("c1_id_valid", {31'b0, id_valid}, 32'd0);
    check("c1_addr", imem_addr, 32'h4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("seq_valid", {31'b0, id_valid}, 32'd1);
      check("seq_pc", id.pc, 32'(4 * k));
      check("seq_ir", id.ir, 32'(4 * k));
    end

    // Reset while id_valid, then decode backpressure
    reset    = 1'b1;
    id_ready = 1'b0;
    #1;
    check("mid_rst_imem_valid", {31'b0, imem_valid}, 32'd0);
    @(negedge clk);
    check("mid_rst_id_valid", {31'b0, id_valid}, 32'd0);
    reset = 1'b0;
    base  = req_cnt;
    #1;
    check("mid_rst_addr", imem_addr, RESET_ADDR);
    check("mid_rst_req", {31'b0, imem_valid}, 32'd1);
    repeat (5) @(negedge clk);
    check("bp_req_count", 32'(req_cnt - base), 32'd2);
    check("bp_imem_valid", {31'b0, imem_valid}, 32'd0);
    check("bp_pc", imem_addr, 32'h8);
    check("bp_id0", id.pc, 32'h0);
    id_ready = 1'b1;
    @(negedge clk);
    check("bp_id1", id.pc, 32'h4);
    @(negedge clk);
    check("bp_id2", id.pc, 32'h8);

    // TRAP with request and response in the same cycle
    lat_min = 1;
    lat_max = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    check("tr_id0", id.pc, 32'h0);
    @(negedge clk);
    check("tr_id1", id.pc, 32'h4);
    check("tr_addr", imem_addr, 32'hC);
    check("tr_rvalid", {31'b0, imem_rvalid}, 32'd1);
    pc_sel = TRAP;
    @(negedge clk);
    pc_sel = NEXT;
    check("tr_flush", {31'b0, id_valid}, 32'd0);
    check("tr_addr2", imem_addr, TRAP_ADDR);
    wait_id("tr_first", 32'h4);
    wait_id("tr_second", 32'h8);

    // ADDR redirect with two outstanding requests
    lat_min = 3;
    lat_max = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    check("jmp_stall", {31'b0, imem_valid}, 32'd0);
    pc_sel    = ADDR;
    pc_target = 32'h0000_0403;
    @(negedge clk);
    pc_sel = NEXT;
    check("jmp_addr", imem_addr, 32'h400);
    check("jmp_flush", {31'b0, id_valid}, 32'd0);
    wait_id("jmp_first", 32'h400);
    wait_id("jmp_second", 32'h404);

    // Random imem_ready / id_ready with 1-3 cycle latency
    lat_min = 1;
    lat_max = 3;
    do_reset();
    exp_pc = 32'h0;
    got_n  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(1, 0));
      id_ready   = ($urandom_range(3, 0) != 0);
      #1;
      if (id_valid && id_ready) begin
        check("rnd_pc", id.pc, exp_pc);
        check("rnd_ir", id.ir, exp_pc);
        exp_pc = exp_pc + 32'd4;
        got_n++;
      end
    end
    check("rnd_enough", {31'b0, got_n >= 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_fetch.md
# rv32_fetch

Instruction fetch stage of the rv32 pipeline: holds the program counter, issues word requests to instruction memory over a valid/ready request channel, and pairs each in-order response with its PC. The result is an `rv32::id_t` handed to decode through a valid/ready handshake. It accepts PC redirects (branch/jump target or trap) from downstream, discarding every fetch still in flight. Up to two fetches are in flight or buffered, giving one instruction per cycle against single-cycle memory.

## Interface
- `RESET_PC`, default `rv32::RESET_ADDR`: PC fetched first after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_valid`  out  1  fetch request valid.
- `imem_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  word-aligned fetch address; `[1:0]` always 0.
- `imem_rvalid`  in  1  response valid; responses return in request order, one per accepted request; there is no backpressure.
- `imem_rdata`  in  32  instruction word.
- `id`  out  `$bits(rv32::id_t)`  `{pc, ir}` to decode.
- `id_valid`  out  1  `id` valid.
- `id_ready`  in  1  decode accepts `id`.
- `pc_sel`  in  `rv32::pc_t`  `NEXT` = no redirect; `ADDR` = jump to `pc_target`; `TRAP` = jump to `rv32::TRAP_ADDR`.
- `pc_target`  in  32  redirect target; bits `[1:0]` ignored (treated as 0).

## Operation
- State:
  - `pc`: next address to request.
  - `outstanding`: accepted requests with no response yet, 0–2.
  - `kill`: responses still to be discarded, 0–2, always ≤ `outstanding`.
  - 2-entry tag FIFO holding the PC of each outstanding request.
  - 2-entry output FIFO of `id_t`.
- Reset values: `pc = RESET_PC`; `outstanding = kill = 0`; both FIFOs empty; `imem_valid = 0` while `reset` is high; `id_valid = 0`; `id = {32'h0, rv32::NOP}` whenever the output FIFO is empty.
- Issue:
  - `imem_valid = !reset && (outstanding + count - (id_valid && id_ready)) < 2`, where `count` is the output-FIFO occupancy.
  - `imem_addr = pc`.
  - `imem_valid` never depends on `pc_sel`. Once asserted, the request stays stable until accepted or until a redirect changes `pc`.
- Request handshake (`imem_valid && imem_ready`): push `pc` into the tag FIFO, `outstanding++`, `pc += 4` (mod 2^32).
- Response:
  - Pop the tag FIFO and decrement `outstanding`.
  - If `kill > 0`, decrement `kill` and drop the response.
  - Otherwise push `{tag, imem_rdata}` into the output FIFO.
- Output: `id` and `id_valid` come from the output-FIFO head; a pop happens on `id_valid && id_ready`.
- Redirect (`pc_sel != NEXT`):
  - `pc <=` the target (for `TRAP`, `rv32::TRAP_ADDR`). This overrides the `+4` from a request handshake in the same cycle.
  - Output FIFO is cleared.
  - `kill <= outstanding_next`, i.e. after this cycle's request and response updates. A request accepted in the redirect cycle is therefore killed.
  - A response arriving in the redirect cycle is dropped.
  - An `id` handshake in the redirect cycle still completes (decode owns that instruction).
- Reset mid-operation discards everything. Responses to pre-reset requests are a system error; memory is reset together with fetch.

## Timing
- Single-cycle memory, `imem_ready = 1`, `id_ready = 1`:
  - First request at cycle 0 after `reset` falls.
  - First response at cycle 1.
  - `id_valid` first rises at cycle 2.
  - Steady state: one `id` per cycle with consecutive PCs.
- Output is registered with no response-to-`id` bypass, so fetch latency is memory latency + 1.
- After a redirect at cycle T, the target is requested at T+1 (if credit allows). Its `id` appears no earlier than T+3 with single-cycle memory.
- With `id_ready = 0`, at most 2 instructions are buffered or outstanding. `imem_valid` then drops and `pc` holds.

## Structure
- Shared package additions: none required. The block uses `rv32::id_t`, `pc_t`, `word_t`, `NOP`, `RESET_ADDR`, `TRAP_ADDR`.
- Sub-module: `rv32_fifo`, a parameterised width, 2-entry synchronous FIFO with synchronous clear. It is instantiated twice, once as the tag FIFO and once as the output FIFO.

## Test plan
- Reset release, ideal memory (one-cycle response, `imem_rdata = addr`), `id_ready = 1` -> `id.pc` = 0x0, 0x4, 0x8…, one per cycle from cycle 2; `ir` equals `pc`.
- `id_ready` held low for 5 cycles -> exactly 2 requests issued, `pc` frozen at 0x8; both instructions are delivered in order when `id_ready` returns high.
- `pc_sel = ADDR`, `pc_target = 0x0000_0403`, with 2 requests outstanding -> both responses dropped; next `id.pc = 0x400`, then 0x404.
- `pc_sel = TRAP` in the same cycle as a request handshake and a response -> that request's response is dropped; next `id.pc = 0x4`.
- `imem_ready` random 50%, response latency 1–3 cycles -> `id` stream is gapless in PC order with no duplicates or losses.
- `reset` asserted for one cycle while `id_valid = 1` -> next cycle `id_valid = 0`, `imem_valid = 0`; the next request is to `RESET_PC`.
